data_path: RTL

8-bit datapath of the TI170 processor, directly downstream of `control_unit`. It holds PC, MAR, MARR, PR, IR, A, B, C and CCR, routes them over Bus1/Bus2 and contains the ALU. It executes the per-cycle control word from `control_unit` and returns IR and CCR_Result to it. It addresses program memory through MAR and answer memory through MARR.

---
 rtl/data_path.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/data_path.sv
`default_nettype none
// ============================================================================
//  Module      : data_path
//  Description : 8-bit TI170 datapath. Holds PC, MAR, MARR, PR, IR, A, B, C
//                and CCR, routes them over Bus1/Bus2 and contains the ALU.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_path (
  input  logic       clock,
  input  logic       reset,
  input  logic       IR_Load,
  input  logic       MAR_Load,
  input  logic       MARR_Load,
  input  logic       PC_Load,
  input  logic       PR_Load,
  input  logic       PC_Inc,
  input  logic       A_Load,
  input  logic       B_Load,
  input  logic       CCR_Load,
  input  logic [3:0] ALU_Sel,
  input  logic [1:0] Bus1_Sel,
  input  logic [1:0] Bus2_Sel,
  input  logic [7:0] from_memory,
  output logic [7:0] IR,
  output logic       CCR_Result,
  output logic [7:0] address,
  output logic [7:0] answer_address,
  output logic [7:0] to_memory,
  output logic [3:0] CCR
);

  logic [7:0] pc_q, pc_d, mar_q, mar_d, marr_q, marr_d, pr_q, pr_d;
  logic [7:0] ir_q, ir_d, a_q, a_d, b_q, b_d, c_q, c_d;
  logic [3:0] ccr_q, ccr_d;

  logic [7:0]  bus1, bus2, alu_r;
  logic        alu_v, alu_c;
  logic [8:0]  sum9, diff9;
  logic [15:0] prod16;

  // Bus1/Bus2 source selection; no storage on either bus.
  always_comb begin
    case (Bus1_Sel)
      2'b00:   bus1 = pc_q;
      2'b01:   bus1 = a_q;
      2'b10:   bus1 = b_q;
      default: bus1 = c_q;
    endcase
    case (Bus2_Sel)
      2'b00:   bus2 = alu_r;
      2'b01:   bus2 = 8'h01;
      2'b10:   bus2 = from_memory;
      default: bus2 = bus1;
    endcase
  end

  // ALU on pre-edge A and B; N and Z are derived from the result for every op.
  always_comb begin
    sum9   = {1'b0, a_q} + {1'b0, b_q};
    diff9  = {1'b0, a_q} - {1'b0, b_q};
    prod16 = {8'h00, a_q} * {8'h00, b_q};
    alu_r  = 8'h00;
    alu_v  = 1'b0;
    alu_c  = 1'b0;
    case (ALU_Sel)
      4'h0: begin
        alu_r = sum9[7:0];
        alu_c = sum9[8];
        alu_v = (a_q[7] == b_q[7]) && (sum9[7] != a_q[7]);
      end
      4'h1, 4'h5: begin
        alu_r = diff9[7:0];
        alu_c = diff9[8];
        alu_v = (a_q[7] != b_q[7]) && (diff9[7] != a_q[7]);
      end
      4'h2: begin
        alu_r = prod16[7:0];
        alu_v = |prod16[15:8];
      end
      4'h3: begin
        if (b_q == 8'h00) begin
          alu_r = 8'hFF;
          alu_v = 1'b1;
        end else begin
          alu_r = a_q / b_q;
        end
      end
      4'h4: begin
        if (b_q == 8'h00) begin
          alu_r = 8'hFF;
          alu_v = 1'b1;
        end else begin
          alu_r = a_q % b_q;
        end
      end
      4'h6: alu_r = a_q & b_q;
      4'h7: alu_r = a_q | b_q;
      4'h8: alu_r = ~a_q;
      4'hA: alu_r = a_q ^ b_q;
      4'hB: alu_r = ~(a_q & b_q);
      4'hC: alu_r = ~(a_q | b_q);
      4'hD: alu_r = ~(a_q ^ b_q);
      default: alu_r = 8'h00;
    endcase
  end

  // Next-state for every register; each strobe acts independently.
  always_comb begin
    ir_d   = IR_Load  ? bus2 : ir_q;
    a_d    = A_Load   ? bus2 : a_q;
    b_d    = B_Load   ? bus2 : b_q;
    mar_d  = MAR_Load ? bus1 : mar_q;
    marr_d = MARR_Load ? pr_q : marr_q;
    pc_d   = pc_q;
    if (PC_Load)     pc_d = bus2;
    else if (PC_Inc) pc_d = pc_q + 8'd1;
    // A simultaneous PR_Load overrides the post-store increment.
    pr_d   = pr_q;
    if (PR_Load)        pr_d = bus2;
    else if (MARR_Load) pr_d = pr_q + 8'd1;
    ccr_d  = ccr_q;
    c_d    = c_q;
    if (CCR_Load) begin
      ccr_d = {alu_r[7], (alu_r == 8'h00), alu_v, alu_c};
      c_d   = alu_r;
    end
  end

  // Register bank with asynchronous active-low clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q   <= 8'h00;
      mar_q  <= 8'h00;
      marr_q <= 8'h00;
      pr_q   <= 8'h00;
      ir_q   <= 8'h00;
      a_q    <= 8'h00;
      b_q    <= 8'h00;
      c_q    <= 8'h00;
      ccr_q  <= 4'b0000;
    end else begin
      pc_q   <= pc_d;
      mar_q  <= mar_d;
      marr_q <= marr_d;
      pr_q   <= pr_d;
      ir_q   <= ir_d;
      a_q    <= a_d;
      b_q    <= b_d;
      c_q    <= c_d;
      ccr_q  <= ccr_d;
    end
  end

  assign IR             = ir_q;
  assign address        = mar_q;
  assign answer_address = marr_q;
  assign CCR            = ccr_q;
  assign CCR_Result     = ccr_q[2];
  assign to_memory      = bus1;

endmodule
`default_nettype wire
